// File: rtl/apb_bank_arbiter.sv
// Two-requester round-robin front end for the shared APB port toward the GPIO banks.
// Sequences SETUP/ACCESS with a pready timeout and returns a one-cycle ack to the winner.
module apb_bank_arbiter #(
  parameter int unsigned BANK_NUM   = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  m0_req_i,
  input  logic                  m0_write_i,
  input  logic [BANK_NUM-1:0]   m0_sel_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_ack_o,
  input  logic                  m1_req_i,
  input  logic                  m1_write_i,
  input  logic [BANK_NUM-1:0]   m1_sel_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_ack_o,
  output logic [DATA_WIDTH-1:0] m_rdata_o,
  output logic                  m_err_o,
  output logic [BANK_NUM-1:0]   b_psel_o,
  output logic                  b_penable_o,
  output logic                  b_pwrite_o,
  output logic [ADDR_WIDTH-1:0] b_paddr_o,
  output logic [DATA_WIDTH-1:0] b_pwdata_o,
  input  logic [DATA_WIDTH-1:0] b_prdata_i,
  input  logic                  b_pready_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state_q,      state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q,      grant_d;
  logic [CNT_W-1:0]      wait_cnt_q,   wait_cnt_d;
  logic [BANK_NUM-1:0]   psel_q,       psel_d;
  logic                  penable_q,    penable_d;
  logic                  pwrite_q,     pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,      paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,     pwdata_d;
  logic                  ack0_q,       ack0_d;
  logic                  ack1_q,       ack1_d;
  logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;
  logic                  err_q,        err_d;

  logic                  win_c;
  logic                  cmd_write_c;
  logic [BANK_NUM-1:0]   cmd_sel_c;
  logic [ADDR_WIDTH-1:0] cmd_addr_c;
  logic [DATA_WIDTH-1:0] cmd_wdata_c;
  logic                  sel_onehot_c;
  logic                  timeout_c;

  // On a tie the requester not served last wins; a lone requester always wins.
  assign win_c        = (m0_req_i && m1_req_i) ? ~last_grant_q : m1_req_i;
  assign cmd_write_c  = win_c ? m1_write_i : m0_write_i;
  assign cmd_sel_c    = win_c ? m1_sel_i   : m0_sel_i;
  assign cmd_addr_c   = win_c ? m1_addr_i  : m0_addr_i;
  assign cmd_wdata_c  = win_c ? m1_wdata_i : m0_wdata_i;
  assign sel_onehot_c = (cmd_sel_c != '0) &&
                        ((cmd_sel_c & (cmd_sel_c - BANK_NUM'(1))) == '0);
  assign timeout_c    = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wait_cnt_d   = wait_cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = '0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          last_grant_d = win_c;
          grant_d      = win_c;
          pwrite_d     = cmd_write_c;
          paddr_d      = cmd_addr_c;
          pwdata_d     = cmd_wdata_c;
          if (sel_onehot_c) begin
            state_d = S_SETUP;
            psel_d  = cmd_sel_c;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
            ack0_d  = ~win_c;
            ack1_d  = win_c;
          end
        end
      end
      S_SETUP: begin
        state_d    = S_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      S_ACCESS: begin
        if (b_pready_i || timeout_c) begin
          state_d   = S_DONE;
          psel_d    = '0;
          penable_d = 1'b0;
          ack0_d    = ~grant_q;
          ack1_d    = grant_q;
          err_d     = ~b_pready_i;
          rdata_d   = (b_pready_i && !pwrite_q) ? b_prdata_i : '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wait_cnt_q   <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wait_cnt_q   <= wait_cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign m0_ack_o    = ack0_q;
  assign m1_ack_o    = ack1_q;
  assign m_rdata_o   = rdata_q;
  assign m_err_o     = err_q;
  assign b_psel_o    = psel_q;
  assign b_penable_o = penable_q;
  assign b_pwrite_o  = pwrite_q;
  assign b_paddr_o   = paddr_q;
  assign b_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_bank_arbiter.sv
// Directed bench for apb_bank_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_apb_bank_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m0_write, m1_req, m1_write;
  logic [1:0] m0_sel, m1_sel;
  logic [2:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_ack, m1_ack;
  logic [7:0] m_rdata;
  logic       m_err;
  logic [1:0] b_psel;
  logic       b_penable, b_pwrite;
  logic [2:0] b_paddr;
  logic [7:0] b_pwdata, b_prdata;
  logic       b_pready;

  int checks = 0;
  int errors = 0;

  apb_bank_arbiter #(
    .BANK_NUM(2), .DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(m0_req), .m0_write_i(m0_write), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack),
    .m1_req_i(m1_req), .m1_write_i(m1_write), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack),
    .m_rdata_o(m_rdata), .m_err_o(m_err),
    .b_psel_o(b_psel), .b_penable_o(b_penable), .b_pwrite_o(b_pwrite),
    .b_paddr_o(b_paddr), .b_pwdata_o(b_pwdata),
    .b_prdata_i(b_prdata), .b_pready_i(b_pready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_write = 1'b0; m0_sel = 2'b00; m0_addr = 3'd0; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_write = 1'b0; m1_sel = 2'b00; m1_addr = 3'd0; m1_wdata = 8'h00;
    b_pready = 1'b1; b_prdata = 8'h00;
    repeat (3) tick();

    check("rst_psel",    32'(b_psel),    32'h0);
    check("rst_penable", 32'(b_penable), 32'h0);
    check("rst_ack0",    32'(m0_ack),    32'h0);
    check("rst_ack1",    32'(m1_ack),    32'h0);
    check("rst_pwrite",  32'(b_pwrite),  32'h0);
    check("rst_paddr",   32'(b_paddr),   32'h0);
    reset = 1'b0;

    // m0 zero-wait write
    m0_req = 1'b1; m0_write = 1'b1; m0_sel = 2'b10; m0_addr = 3'd5; m0_wdata = 8'hA5;
    tick();
    check("t1_psel_n1",    32'(b_psel),    32'h2);
    check("t1_penable_n1", 32'(b_penable), 32'h0);
    check("t1_pwrite",     32'(b_pwrite),  32'h1);
    check("t1_paddr",      32'(b_paddr),   32'h5);
    check("t1_pwdata",     32'(b_pwdata),  32'hA5);
    tick();
    check("t1_penable_n2", 32'(b_penable), 32'h1);
    check("t1_psel_n2",    32'(b_psel),    32'h2);
    check("t1_ack0_n2",    32'(m0_ack),    32'h0);
    tick();
    check("t1_ack0_n3",    32'(m0_ack),    32'h1);
    check("t1_err",        32'(m_err),     32'h0);
    check("t1_ack1",       32'(m1_ack),    32'h0);
    check("t1_psel_n3",    32'(b_psel),    32'h0);
    m0_req = 1'b0;
    tick();
    check("t1_ack0_n4",    32'(m0_ack),    32'h0);

    // m1 read with three wait states
    m1_req = 1'b1; m1_write = 1'b0; m1_sel = 2'b01; m1_addr = 3'd2;
    b_pready = 1'b0; b_prdata = 8'h3C;
    tick();
    check("t2_psel",   32'(b_psel),   32'h1);
    check("t2_pwrite", 32'(b_pwrite), 32'h0);
    check("t2_paddr",  32'(b_paddr),  32'h2);
    tick(); tick(); tick();
    check("t2_ack1_n4", 32'(m1_ack), 32'h0);
    tick();
    b_pready = 1'b1;
    check("t2_ack1_n5", 32'(m1_ack), 32'h0);
    tick();
    check("t2_ack1_n6", 32'(m1_ack),  32'h1);
    check("t2_rdata",   32'(m_rdata), 32'h3C);
    check("t2_err",     32'(m_err),   32'h0);
    check("t2_ack0",    32'(m0_ack),  32'h0);
    m1_req = 1'b0;
    tick();

    // Both held: grants alternate m0, m1, m0, m1 every 4 cycles
    m0_req = 1'b1; m0_write = 1'b1; m0_sel = 2'b01; m0_addr = 3'd1; m0_wdata = 8'h11;
    m1_req = 1'b1; m1_write = 1'b1; m1_sel = 2'b10; m1_addr = 3'd6; m1_wdata = 8'h22;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_paddr", 32'(b_paddr), (k % 2 == 0) ? 32'h1 : 32'h6);
      check("t3_psel",  32'(b_psel),  (k % 2 == 0) ? 32'h1 : 32'h2);
      tick(); tick();
      check("t3_ack0", 32'(m0_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
      check("t3_ack1", 32'(m1_ack), (k % 2 == 0) ? 32'h0 : 32'h1);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // m0 read, pready stuck low: error ack at N+18
    m0_req = 1'b1; m0_write = 1'b0; m0_sel = 2'b01; m0_addr = 3'd3;
    b_pready = 1'b0; b_prdata = 8'h77;
    repeat (17) tick();
    check("t4_psel_n17",    32'(b_psel),    32'h1);
    check("t4_penable_n17", 32'(b_penable), 32'h1);
    check("t4_ack0_n17",    32'(m0_ack),    32'h0);
    tick();
    check("t4_ack0_n18",    32'(m0_ack),    32'h1);
    check("t4_err",         32'(m_err),     32'h1);
    check("t4_rdata",       32'(m_rdata),   32'h0);
    check("t4_psel_n18",    32'(b_psel),    32'h0);
    check("t4_penable_n18", 32'(b_penable), 32'h0);
    m0_req = 1'b0;
    tick();

    // pready arriving in the final ACCESS cycle is a success
    m0_req = 1'b1;
    repeat (17) tick();
    b_pready = 1'b1;
    check("t4b_ack0_n17", 32'(m0_ack), 32'h0);
    tick();
    check("t4b_ack0_n18", 32'(m0_ack),  32'h1);
    check("t4b_err",      32'(m_err),   32'h0);
    check("t4b_rdata",    32'(m_rdata), 32'h77);
    m0_req = 1'b0;
    tick();

    // Invalid selects from m1
    m1_req = 1'b1; m1_write = 1'b1; m1_sel = 2'b00;
    tick();
    check("t5a_ack1", 32'(m1_ack), 32'h1);
    check("t5a_err",  32'(m_err),  32'h1);
    check("t5a_psel", 32'(b_psel), 32'h0);
    check("t5a_ack0", 32'(m0_ack), 32'h0);
    m1_req = 1'b0;
    tick();
    m1_req = 1'b1; m1_sel = 2'b11;
    tick();
    check("t5b_ack1", 32'(m1_ack), 32'h1);
    check("t5b_err",  32'(m_err),  32'h1);
    check("t5b_psel", 32'(b_psel), 32'h0);
    m1_req = 1'b0;
    tick();
    check("t5b_psel_after", 32'(b_psel), 32'h0);

    // Reset in ACCESS drops the transfer and restores last_grant
    m0_req = 1'b1; m0_write = 1'b0; m0_sel = 2'b10; m0_addr = 3'd4;
    b_pready = 1'b0;
    tick(); tick();
    check("t6_penable_access", 32'(b_penable), 32'h1);
    reset = 1'b1; m0_req = 1'b0; b_pready = 1'b1;
    tick();
    check("t6_psel_rst",    32'(b_psel),    32'h0);
    check("t6_penable_rst", 32'(b_penable), 32'h0);
    check("t6_ack0_rst",    32'(m0_ack),    32'h0);
    reset = 1'b0;
    tick(); tick();
    check("t6_ack0_after", 32'(m0_ack), 32'h0);
    check("t6_ack1_after", 32'(m1_ack), 32'h0);

    m0_req = 1'b1; m0_write = 1'b0; m0_sel = 2'b10; m0_addr = 3'd4;
    m1_req = 1'b1; m1_write = 1'b0; m1_sel = 2'b01; m1_addr = 3'd7;
    b_prdata = 8'h5A;
    tick();
    check("t6_paddr", 32'(b_paddr), 32'h4);
    check("t6_psel",  32'(b_psel),  32'h2);
    tick(); tick();
    check("t6_ack0",  32'(m0_ack),  32'h1);
    check("t6_ack1",  32'(m1_ack),  32'h0);
    check("t6_rdata", 32'(m_rdata), 32'h5A);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
